// File: rtl/risc_pkg.sv
// Shared fetch-path types: address/instruction widths, queue entry layout, fetch FSM states.
package risc_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with registered storage and a clear input; DEPTH must be a power of two.
module prefetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // a write into a full FIFO is legal when the head leaves in the same cycle
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/prefetch_queue.sv
// Instruction-fetch front end: in-order imem requests, {instr, pc} queue to decode, redirect flush.
// Optional PREFETCH_STATS_EN adds saturating redirect and decode-starve counters.
module prefetch_queue
  import risc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               branch_predict,
  output logic [ADDR_W-1:0]  PC_1,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  IR_PC,
  output logic               IR_valid,
  input  logic               IR_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]        stat_flush,
  output logic [15:0]        stat_starve
`endif
);
  // state | meaning
  // RUN   | fetching; responses are pushed into the queue
  // FLUSH | no requests; discarding drop responses still owed by imem
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, last_pc1, tag_head;
  logic [OW-1:0]     outstanding, outstanding_n, drop, drop_n, tag_count;
  logic              redirect, hs, rsp;
  fetch_entry_t      q_wdata, q_head;
  logic [QCW-1:0]    q_count;
  logic              q_full, q_empty, tag_full, tag_empty;

  assign redirect  = !branch_predict;
  assign imem_req  = !reset && (state == RUN) &&
                     (int'(q_count) + int'(outstanding) < DEPTH) &&
                     (int'(outstanding) < MAX_OUT);
  assign imem_addr = fetch_pc;
  assign hs        = imem_req && imem_gnt;
  assign rsp       = (state == RUN) && imem_rvalid && !tag_empty;
  assign q_wdata   = '{instr: imem_rdata, pc: tag_head};

  prefetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .CLK(CLK), .reset(reset), .clear(redirect),
    .wr_en(rsp), .wr_data(q_wdata), .rd_en(IR_ready), .rd_data(q_head),
    .count(q_count), .full(q_full), .empty(q_empty)
  );

  prefetch_fifo #(.W(ADDR_W), .DEPTH(MAX_OUT)) u_tags (
    .CLK(CLK), .reset(reset), .clear(redirect),
    .wr_en(hs), .wr_data(fetch_pc), .rd_en(rsp), .rd_data(tag_head),
    .count(tag_count), .full(tag_full), .empty(tag_empty)
  );

  assign IR_valid = !q_empty;
  assign IR       = IR_valid ? q_head.instr : '0;
  assign IR_PC    = IR_valid ? q_head.pc : '0;
  assign PC_1     = IR_valid ? q_head.pc + ADDR_W'(1) : last_pc1;

  always_comb begin
    state_n       = state;
    drop_n        = drop;
    outstanding_n = outstanding + OW'(hs) - OW'(rsp);
    case (state)
      RUN: begin
        if (redirect) begin
          // a request granted in the redirect cycle is owed as well
          drop_n        = outstanding + OW'(hs) - OW'(rsp);
          outstanding_n = '0;
          state_n       = (drop_n != '0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        outstanding_n = '0;
        if (imem_rvalid && drop != '0) drop_n = drop - OW'(1);
        if (drop_n == '0) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= '0;
      outstanding <= '0;
      drop        <= '0;
      last_pc1    <= ADDR_W'(1);
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      drop        <= drop_n;
      if (redirect) fetch_pc <= PC;
      else if (hs)  fetch_pc <= fetch_pc + ADDR_W'(1);
      if (IR_valid) last_pc1 <= PC_1;
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stat_flush  <= '0;
      stat_starve <= '0;
    end else begin
      if (redirect && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
      if (!IR_valid && IR_ready && stat_starve != 16'hFFFF) stat_starve <= stat_starve + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
    !(rsp && q_full && !IR_ready && !redirect));
  a_tags_track: assert property (@(posedge CLK) disable iff (reset)
    (tag_count == outstanding) && !(hs && tag_full && !rsp));
endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: imem model with 1-cycle response, expected PCs queued on issue.
module tb_prefetch_queue;
  import risc_pkg::*;

  logic        CLK = 1'b0;
  logic        reset = 1'b1, branch_predict = 1'b1, imem_gnt = 1'b0, imem_rvalid = 1'b0, IR_ready = 1'b0;
  logic [7:0]  PC = 8'h00;
  logic [31:0] imem_rdata = 32'h0;
  logic [7:0]  PC_1, imem_addr, IR_PC;
  logic        imem_req, IR_valid;
  logic [31:0] IR;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush, stat_starve;
  logic [15:0] s_sflush, s_sstarve;
`endif

  prefetch_queue dut (
    .CLK(CLK), .reset(reset), .PC(PC), .branch_predict(branch_predict), .PC_1(PC_1),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IR(IR), .IR_PC(IR_PC), .IR_valid(IR_valid), .IR_ready(IR_ready)
`ifdef PREFETCH_STATS_EN
    , .stat_flush(stat_flush), .stat_starve(stat_starve)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit rst_k = 1'b1, gnt_k = 1'b0, rsp_k = 1'b0, rdy_k = 1'b0, bp_k = 1'b1;
  logic [7:0]  pc_k = 8'h00;
  logic [7:0]  model_pc = 8'h00;
  logic [7:0]  exp_q[$];
  logic [7:0]  rsp_q[$];
  logic        s_req, s_valid;
  logic [7:0]  s_addr, s_irpc, s_pc1, last_pop;
  logic [31:0] s_ir;
  int          pops = 0, hss = 0;

  function automatic logic [31:0] mk(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one clock: sample outputs, drive knobs, update model with what the next posedge will do
  task automatic step();
    logic [7:0] a, e, e1;
    @(negedge CLK);
    s_valid = IR_valid; s_ir = IR; s_irpc = IR_PC; s_pc1 = PC_1;
`ifdef PREFETCH_STATS_EN
    s_sflush = stat_flush; s_sstarve = stat_starve;
`endif
    reset = rst_k; imem_gnt = gnt_k; IR_ready = rdy_k; branch_predict = bp_k; PC = pc_k;
    if (rsp_k && rsp_q.size() > 0) begin
      a = rsp_q.pop_front();
      imem_rvalid = 1'b1; imem_rdata = mk(a);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr;
    if (rst_k) begin
      exp_q.delete();
      model_pc = 8'h00;
    end else begin
      if (s_valid && rdy_k) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          e1 = e + 8'd1;
          chk("ir_pc", s_irpc, e);
          chk("ir", s_ir, mk(e));
          chk("pc_1", s_pc1, e1);
          last_pop = e;
          pops++;
        end
      end
      if (s_req && gnt_k) begin
        chk("imem_addr", s_addr, model_pc);
        rsp_q.push_back(s_addr);
        hss++;
        if (bp_k) exp_q.push_back(model_pc);
        model_pc = model_pc + 8'd1;
      end
      if (!bp_k) begin
        exp_q.delete();
        model_pc = pc_k;
      end
    end
  endtask

  task automatic do_reset(input bit keep_rsp);
    if (!keep_rsp) rsp_q.delete();
    rst_k = 1'b1; gnt_k = 1'b0; rsp_k = 1'b0; rdy_k = 1'b0; bp_k = 1'b1;
    step(); step();
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (pops < target && n < 60) begin step(); n++; end
    chk(tag, 32'(pops >= target), 1);
  endtask

  initial begin
    int n, p0, h0;
    bit seen;

    // reset values
    do_reset(1'b0);
    chk("rst_req", s_req, 0);   chk("rst_addr", s_addr, 0); chk("rst_ir", s_ir, 0);
    chk("rst_irpc", s_irpc, 0); chk("rst_valid", s_valid, 0); chk("rst_pc1", s_pc1, 1);

    // 1: streaming, one pop per cycle after 1-cycle response + 1-cycle queue latency
    rst_k = 1'b0; gnt_k = 1'b1; rsp_k = 1'b1; rdy_k = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin step(); n++; seen = s_valid; end
    chk("t1_seen", seen, 1);
    chk("t1_latency", n, 3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("t1_valid", s_valid, 1);
      chk("t1_irpc", s_irpc, i);
    end

    // 2: decode stalled -> exactly DEPTH fetched, then resume at 4
    do_reset(1'b0);
    rst_k = 1'b0; gnt_k = 1'b1; rsp_k = 1'b1; rdy_k = 1'b0;
    h0 = hss; p0 = pops;
    repeat (10) step();
    chk("t2_fetched", hss - h0, 4);
    chk("t2_req_off", s_req, 0);
    chk("t2_hold_valid", s_valid, 1);
    chk("t2_hold_pc", s_irpc, 0);
    rdy_k = 1'b1;
    wait_pops(p0 + 8, "t2_resume_done");
    chk("t2_last", last_pop, 7);

    // 3: redirect with two outstanding -> both dropped, refetch from 0x40
    do_reset(1'b0);
    rst_k = 1'b0; gnt_k = 1'b1; rsp_k = 1'b0; rdy_k = 1'b1;
    repeat (3) step();
    chk("t3_out_limit", s_req, 0);
    bp_k = 1'b0; pc_k = 8'h40;
    step();
    bp_k = 1'b1; rsp_k = 1'b1;
    step(); chk("t3_flush_req1", s_req, 0);
    step(); chk("t3_flush_req2", s_req, 0);
    step(); chk("t3_run_req", s_req, 1); chk("t3_run_addr", s_addr, 8'h40);
    p0 = pops;
    wait_pops(p0 + 1, "t3_first_pop");
    chk("t3_first_pc", last_pop, 8'h40);

    // 4: redirect with a full queue clears it; sequential wrap 0xFE,0xFF,0x00
    do_reset(1'b0);
    rst_k = 1'b0; gnt_k = 1'b1; rsp_k = 1'b1; rdy_k = 1'b0;
    repeat (6) step();
    chk("t4_full_valid", s_valid, 1);
    bp_k = 1'b0; pc_k = 8'hFE;
    step();
    bp_k = 1'b1; rdy_k = 1'b1;
    step(); chk("t4_cleared", s_valid, 0);
    p0 = pops;
    wait_pops(p0 + 3, "t4_wrap_pops");
    chk("t4_wrap_pc", last_pop, 8'h00);

    // 5: reset with two outstanding and queued entries; late responses ignored
    do_reset(1'b0);
    rst_k = 1'b0; gnt_k = 1'b1; rsp_k = 1'b0; rdy_k = 1'b0;
    repeat (2) step();
    rsp_k = 1'b1;
    repeat (2) step();
    rst_k = 1'b1; gnt_k = 1'b0; rsp_k = 1'b0;
    step();
    step(); chk("t5_valid_after_rst", s_valid, 0);
    rst_k = 1'b0; rsp_k = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_late_ignored", s_valid, 0);
    end
    gnt_k = 1'b1; rdy_k = 1'b1;
    p0 = pops;
    wait_pops(p0 + 1, "t5_refetch");
    chk("t5_first_pc", last_pop, 8'h00);

`ifdef PREFETCH_STATS_EN
    // 6: 3 redirects and 5 starved cycles
    do_reset(1'b0);
    chk("t6_rst_flush", s_sflush, 0);
    chk("t6_rst_starve", s_sstarve, 0);
    rst_k = 1'b0; gnt_k = 1'b0; rsp_k = 1'b0; rdy_k = 1'b0;
    bp_k = 1'b0; pc_k = 8'h10;
    repeat (3) step();
    bp_k = 1'b1; rdy_k = 1'b1;
    repeat (5) step();
    rdy_k = 1'b0;
    repeat (2) step();
    chk("t6_flush", s_sflush, 3);
    chk("t6_starve", s_sstarve, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
